hs32_mem_arb: RTL and testbench
===============================

Name: hs32_mem_arb

Overview:
Two-port memory arbiter that shares the single soc_bram_ctl valid/ready port between the execute unit (port A) and the instruction fetch unit (port B). Each requester presents a held request. The arbiter selects one requester, registers its address, direction and write data, and drives the memory port. It returns read data with a one-cycle done pulse. An optional watchdog aborts transactions the memory never acknowledges.

Parameters:
AW, 32, address width on all ports
DW, 32, data width on all ports
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority to port A (exec)
TIMEOUT, 0, cycles in BUSY without ready_m before abort; 0 disables the watchdog
TW, 8, watchdog counter width; TIMEOUT must be less than 2^TW

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
req_a  in  1  exec request; held high until rdy_a
rw_a  in  1  exec direction; 1 = write, 0 = read
addr_a  in  AW  exec address
dtw_a  in  DW  exec write data
rdy_a  out  1  exec done pulse, one cycle
err_a  out  1  exec abort flag; valid only while rdy_a is high
dtr_a  out  DW  exec read data; valid while rdy_a is high, held afterwards
req_b, rw_b, addr_b, dtw_b, rdy_b, err_b, dtr_b  same as the port A signals, for fetch
addr_m  out  AW  memory address
rw_m  out  1  memory direction
dtw_m  out  DW  memory write data
valid_m  out  1  memory request
ready_m  in  1  memory completion
dtr_m  in  DW  memory read data; valid when ready_m is high
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): state <= IDLE; valid_m, rw_m, rdy_a, rdy_b, err_a, err_b, busy = 0; addr_m, dtw_m, dtr_a, dtr_b = 0; gnt (registered winner) = B; last = B; wdog = 0.
- Reset asserted mid-transaction: the transaction is dropped silently and no rdy pulse is generated. The memory side must tolerate valid_m falling without ready_m.
- States: IDLE, BUSY, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, any req_x high: the winner is chosen this cycle. On the edge:
  - gnt <= winner; last <= winner
  - addr_m/rw_m/dtw_m <= winner's inputs
  - valid_m <= 1; wdog <= 0
  - state <= BUSY
- Arbitration:
  - Only one request high: that requester wins.
  - Both high, PRIO_MODE=0: the requester not equal to last wins, so A wins first after reset.
  - Both high, PRIO_MODE=1: A always wins, and B may starve.
- BUSY: valid_m, addr_m, rw_m and dtw_m are held stable.
  - ready_m=1: valid_m <= 0; dtr_gnt <= dtr_m if rw_m=0 (write leaves dtr unchanged); rdy_gnt <= 1; err_gnt <= 0; state <= DONE.
  - ready_m=0 and TIMEOUT!=0: wdog increments. When wdog==TIMEOUT-1 and ready_m is still 0: valid_m <= 0; rdy_gnt <= 1; err_gnt <= 1; dtr unchanged; state <= DONE.
  - ready_m and timeout in the same cycle: ready_m wins, err=0.
- DONE: lasts exactly one cycle with rdy_gnt (and err_gnt on abort) high. All requests are ignored. On the edge: rdy/err <= 0; state <= IDLE.
- Requester contract: after sampling rdy_x high, the requester either drops req_x or updates addr/rw/dtw for a back-to-back access. The arbiter samples again in IDLE on the following cycle.
- Request dropped while BUSY: the transaction still completes and rdy still pulses. The memory side is never cancelled.
- Latency: req high (IDLE) at edge 0 gives valid_m=1 after edge 0. ready_m seen at edge k gives rdy=1 after edge k. Minimum is 3 cycles per access; peak throughput is 1 access per 3 cycles.
- ready_m outside BUSY is ignored. dtr_m is sampled only in BUSY when ready_m=1.
- busy = (state != IDLE), registered.

Test Plan:
1. Single read: req_a=1, addr_a=0x10, rw_a=0; memory returns 0xCAFE with ready_m on the first BUSY cycle. Required: valid_m high for 1 cycle with addr_m=0x10; rdy_a pulse on cycle 2 with dtr_a=0xCAFE, err_a=0; rdy_b never pulses.
2. Contention, round-robin: req_a and req_b held high for 4 accesses, addr_a=0x4, addr_b=0x8, PRIO_MODE=0. Required: grant order A,B,A,B; addr_m sequence 0x4,0x8,0x4,0x8; one rdy per access, 3 cycles apart.
3. Fixed priority: PRIO_MODE=1, both requesting continuously for 3 accesses. Required: all 3 grants go to A; rdy_b stays 0. Then drop req_a: B is granted on the next IDLE cycle.
4. Write: req_b=1, rw_b=1, dtw_b=0xDEADBEEF, addr_b=0x20. Required: dtw_m=0xDEADBEEF and rw_m=1 for the whole of BUSY; dtr_b unchanged after completion.
5. Watchdog: TIMEOUT=5, ready_m held at 0. Required: valid_m high for exactly 5 cycles, then rdy_a=1 with err_a=1; state returns to IDLE. Repeat with ready_m=1 on the 5th BUSY cycle: err_a=0.
6. Reset mid-op: reset=0 asserted asynchronously (between clock edges) during BUSY. Required: valid_m=0 and busy=0 immediately, no rdy pulse. After release with both requesting: A is granted first.

Source files
------------

// File: rtl/hs32_mem_arb.sv
// hs32_mem_arb: shares one valid/ready memory port between exec (A) and fetch (B).
// Ports: clk, reset (async, active-low); per requester req/rw/addr/dtw in and
// rdy/err/dtr out; memory side addr_m/rw_m/dtw_m/valid_m out, ready_m/dtr_m in;
// busy is high whenever the arbiter is not idle.
module hs32_mem_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 0,
    parameter int TW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          rw_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] dtw_a,
    output logic          rdy_a,
    output logic          err_a,
    output logic [DW-1:0] dtr_a,
    input  logic          req_b,
    input  logic          rw_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] dtw_b,
    output logic          rdy_b,
    output logic          err_b,
    output logic [DW-1:0] dtr_b,
    output logic [AW-1:0] addr_m,
    output logic          rw_m,
    output logic [DW-1:0] dtw_m,
    output logic          valid_m,
    input  logic          ready_m,
    input  logic [DW-1:0] dtr_m,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] WD_LAST =
        TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state_q, state_d;
    // Requester index encoding: 0 = A (exec), 1 = B (fetch).
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          valid_q, valid_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dtw_q, dtw_d;
    logic          rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
    logic          err_a_q, err_a_d, err_b_q, err_b_d;
    logic [DW-1:0] dtr_a_q, dtr_a_d, dtr_b_q, dtr_b_d;
    logic          busy_q, busy_d;
    logic          win_b;

    // With both requesting, round-robin hands the grant to whoever did not win last.
    always_comb begin
        win_b = req_b;
        if (req_a && req_b) begin
            win_b = (PRIO_MODE != 0) ? 1'b0 : ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        valid_d = valid_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        dtw_d   = dtw_q;
        rdy_a_d = rdy_a_q;
        rdy_b_d = rdy_b_q;
        err_a_d = err_a_q;
        err_b_d = err_b_q;
        dtr_a_d = dtr_a_q;
        dtr_b_d = dtr_b_q;
        unique case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    gnt_d   = win_b;
                    last_d  = win_b;
                    addr_d  = win_b ? addr_b : addr_a;
                    rw_d    = win_b ? rw_b : rw_a;
                    dtw_d   = win_b ? dtw_b : dtw_a;
                    valid_d = 1'b1;
                    wdog_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ready_m) begin
                    valid_d = 1'b0;
                    state_d = DONE;
                    if (gnt_q) begin
                        rdy_b_d = 1'b1;
                        err_b_d = 1'b0;
                        if (!rw_q) dtr_b_d = dtr_m;
                    end else begin
                        rdy_a_d = 1'b1;
                        err_a_d = 1'b0;
                        if (!rw_q) dtr_a_d = dtr_m;
                    end
                end else if (WD_EN) begin
                    if (wdog_q == WD_LAST) begin
                        // Memory never answered: abort and flag the requester.
                        valid_d = 1'b0;
                        state_d = DONE;
                        if (gnt_q) begin
                            rdy_b_d = 1'b1;
                            err_b_d = 1'b1;
                        end else begin
                            rdy_a_d = 1'b1;
                            err_a_d = 1'b1;
                        end
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            DONE: begin
                rdy_a_d = 1'b0;
                rdy_b_d = 1'b0;
                err_a_d = 1'b0;
                err_b_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b1;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            dtw_q   <= '0;
            rdy_a_q <= 1'b0;
            rdy_b_q <= 1'b0;
            err_a_q <= 1'b0;
            err_b_q <= 1'b0;
            dtr_a_q <= '0;
            dtr_b_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            valid_q <= valid_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            dtw_q   <= dtw_d;
            rdy_a_q <= rdy_a_d;
            rdy_b_q <= rdy_b_d;
            err_a_q <= err_a_d;
            err_b_q <= err_b_d;
            dtr_a_q <= dtr_a_d;
            dtr_b_q <= dtr_b_d;
            busy_q  <= busy_d;
        end
    end

    assign addr_m  = addr_q;
    assign rw_m    = rw_q;
    assign dtw_m   = dtw_q;
    assign valid_m = valid_q;
    assign rdy_a   = rdy_a_q;
    assign rdy_b   = rdy_b_q;
    assign err_a   = err_a_q;
    assign err_b   = err_b_q;
    assign dtr_a   = dtr_a_q;
    assign dtr_b   = dtr_b_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_hs32_mem_arb.sv
// tb_hs32_mem_arb: random requesters and memory around two arbiter instances
// (round-robin with TIMEOUT=5, fixed priority without watchdog), scoreboard-checked.
module tb_hs32_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   mode = 0;
    bit   both_on_reset = 1'b0;

    typedef struct {
        int            cyc;
        bit            p;
        bit            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] dtw;
    } gnt_t;

    typedef struct {
        int            cyc;
        bit            p;
        bit            err;
        logic [DW-1:0] dtr;
    } cpl_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int PM = g;
        localparam int TO = (g == 0) ? 5 : 0;

        logic          req [2];
        logic          rw [2];
        logic [AW-1:0] addr [2];
        logic [DW-1:0] dtw [2];
        logic          ready_m;
        logic [DW-1:0] dtr_m;
        logic          rdy_a, rdy_b, err_a, err_b, valid_m, rw_m, busy;
        logic [DW-1:0] dtr_a, dtr_b, dtw_m;
        logic [AW-1:0] addr_m;

        hs32_mem_arb #(
            .AW(AW), .DW(DW), .PRIO_MODE(PM), .TIMEOUT(TO), .TW(8)
        ) dut (
            .clk(clk), .reset(rst),
            .req_a(req[0]), .rw_a(rw[0]), .addr_a(addr[0]), .dtw_a(dtw[0]),
            .rdy_a(rdy_a), .err_a(err_a), .dtr_a(dtr_a),
            .req_b(req[1]), .rw_b(rw[1]), .addr_b(addr[1]), .dtw_b(dtw[1]),
            .rdy_b(rdy_b), .err_b(err_b), .dtr_b(dtr_b),
            .addr_m(addr_m), .rw_m(rw_m), .dtw_m(dtw_m), .valid_m(valid_m),
            .ready_m(ready_m), .dtr_m(dtr_m), .busy(busy)
        );

        // Transaction-level model: phase 0 = free, 1 = memory access open,
        // 2 = completion being reported.
        int            cyc = 0;
        int            phase = 0;
        bit            last = 1'b1;
        int            bc = 0;
        int            lat = 0;
        int            wd = 0;
        bit            w;
        bit            inflight [2];
        bit            done_flag [2];
        logic [DW-1:0] dexp [2];
        gnt_t          gq [$];
        cpl_t          cq [$];
        gnt_t          cur_m;

        task automatic new_req(input int p);
            req[p]  = 1'b1;
            rw[p]   = 1'($urandom_range(0, 1));
            addr[p] = $urandom;
            dtw[p]  = $urandom;
        endtask

        initial begin : model
            for (int p = 0; p < 2; p++) begin
                req[p] = 1'b0; rw[p] = 1'b0; addr[p] = '0; dtw[p] = '0;
                inflight[p] = 1'b0; done_flag[p] = 1'b0; dexp[p] = '0;
            end
            ready_m = 1'b0;
            dtr_m = '0;
            forever begin
                @(posedge clk);
                cyc++;
                done_flag[0] = 1'b0;
                done_flag[1] = 1'b0;
                if (!rst) begin
                    phase = 0; last = 1'b1;
                    dexp[0] = '0; dexp[1] = '0;
                    inflight[0] = 1'b0; inflight[1] = 1'b0;
                    gq.delete(); cq.delete();
                end else begin
                    case (phase)
                        0: if (req[0] || req[1]) begin
                            if (req[0] && req[1]) w = (PM == 1) ? 1'b0 : !last;
                            else w = req[1];
                            last = w;
                            cur_m = '{cyc, w, rw[w], addr[w], dtw[w]};
                            gq.push_back(cur_m);
                            inflight[w] = 1'b1;
                            phase = 1; bc = 0; wd = 0;
                            if (mode == 1) lat = 0;
                            else if (TO != 0 && $urandom_range(0, 7) == 0) lat = 1000;
                            else lat = $urandom_range(0, 7);
                        end
                        1: begin
                            if (ready_m) begin
                                if (!cur_m.rw) dexp[cur_m.p] = dtr_m;
                                cq.push_back('{cyc, cur_m.p, 1'b0, dexp[cur_m.p]});
                                phase = 2;
                            end else if (TO != 0) begin
                                wd++;
                                if (wd == TO) begin
                                    cq.push_back('{cyc, cur_m.p, 1'b1, dexp[cur_m.p]});
                                    phase = 2;
                                end
                            end
                            bc++;
                        end
                        default: begin
                            phase = 0;
                            inflight[cur_m.p] = 1'b0;
                            done_flag[cur_m.p] = 1'b1;
                        end
                    endcase
                end
                #1;
                for (int p = 0; p < 2; p++) begin
                    if (!rst) begin
                        if (both_on_reset) new_req(p);
                        else req[p] = 1'b0;
                    end else if (done_flag[p]) begin
                        if (mode == 1 || $urandom_range(0, 1) == 1) new_req(p);
                        else req[p] = 1'b0;
                    end else if (!req[p] && !inflight[p]) begin
                        if (mode == 1 || $urandom_range(0, 2) == 0) new_req(p);
                    end else if (req[p] && inflight[p] && mode == 0 &&
                                 $urandom_range(0, 15) == 0) begin
                        req[p] = 1'b0;
                    end
                end
                dtr_m = $urandom;
                if (phase == 1) ready_m = (bc == lat);
                else ready_m = ($urandom_range(0, 3) == 0);
            end
        end

        gnt_t gcur;
        cpl_t c;
        bit   vprev = 1'b0;

        always @(negedge clk) begin : monitor
            if (rst) begin
                chk($sformatf("u%0d.valid_m", g), valid_m, phase == 1);
                chk($sformatf("u%0d.busy", g), busy, phase != 0);
                chk($sformatf("u%0d.dtr_a_held", g), dtr_a, dexp[0]);
                chk($sformatf("u%0d.dtr_b_held", g), dtr_b, dexp[1]);
                if (valid_m && !vprev) begin
                    chk($sformatf("u%0d.grant_expected", g), gq.size() != 0, 1);
                    if (gq.size() != 0) begin
                        gcur = gq.pop_front();
                        chk($sformatf("u%0d.grant_cycle", g), cyc, gcur.cyc);
                    end
                end
                if (valid_m) begin
                    chk($sformatf("u%0d.addr_m", g), addr_m, gcur.addr);
                    chk($sformatf("u%0d.rw_m", g), rw_m, gcur.rw);
                    chk($sformatf("u%0d.dtw_m", g), dtw_m, gcur.dtw);
                end
                if (rdy_a || rdy_b) begin
                    chk($sformatf("u%0d.rdy_expected", g), cq.size() != 0, 1);
                    if (cq.size() != 0) begin
                        c = cq.pop_front();
                        chk($sformatf("u%0d.rdy_cycle", g), cyc, c.cyc);
                        chk($sformatf("u%0d.rdy_port", g), {rdy_b, rdy_a},
                            c.p ? 2'b10 : 2'b01);
                        chk($sformatf("u%0d.err", g), c.p ? err_b : err_a, c.err);
                        chk($sformatf("u%0d.dtr", g), c.p ? dtr_b : dtr_a, c.dtr);
                    end
                end else if (cq.size() != 0 && cq[0].cyc <= cyc) begin
                    chk($sformatf("u%0d.rdy_missing", g), rdy_a | rdy_b, 1);
                    void'(cq.pop_front());
                end
                vprev = valid_m;
            end else begin
                chk($sformatf("u%0d.rst_outputs", g),
                    {valid_m, busy, rdy_a, rdy_b}, 4'b0000);
                vprev = 1'b0;
            end
        end

        always @(negedge rst) begin
            #1;
            chk($sformatf("u%0d.async_rst_valid", g), valid_m, 0);
            chk($sformatf("u%0d.async_rst_busy", g), busy, 0);
        end
    end

    initial begin
        int n;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        mode = 0;
        repeat (1500) @(posedge clk);
        mode = 1;
        repeat (300) @(posedge clk);
        mode = 0;
        n = 0;
        @(negedge clk);
        while (u[0].phase != 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reset_wait_busy", u[0].phase == 1, 1);
        #2 rst = 1'b0;
        both_on_reset = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        both_on_reset = 1'b0;
        repeat (1500) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
